// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - synchronous FIFO with registered occupancy flags and optional FWFT read port
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1,
  parameter bit FWFT     = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   w_en,
  input  logic                   r_en,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    w_ptr;
  logic [AW-1:0]    r_ptr;
  logic [CW-1:0]    count_next;
  logic             wr_acc;
  logic             rd_acc;

  // Acceptance looks only at the registered flags, so a same-edge read never
  // frees space for a write and a same-edge write never feeds a read.
  assign wr_acc = w_en & ~full;
  assign rd_acc = r_en & ~empty;

  // Occupancy after this edge; both flags and count are derived from it.
  always_comb begin
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Pointers, occupancy, registered flags and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + AW'(1);
      if (rd_acc) r_ptr <= r_ptr + AW'(1);
      count        <= count_next;
      full         <= (count_next == CW'(DEPTH));
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= CW'(AF_LEVEL));
      almost_empty <= (count_next <= CW'(AE_LEVEL));
      overflow     <= w_en & full;
      underflow    <= r_en & empty;
    end
  end

  // Storage array; contents survive reset and are simply ignored afterwards.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[w_ptr] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is shown combinationally; blanked while the FIFO is empty.
      assign data_out = empty ? '0 : mem[r_ptr];
    end else begin : g_registered
      logic [WIDTH-1:0] dout_q;

      // Capture the head word on each accepted read; hold otherwise.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dout_q <= '0;
        else if (rd_acc) dout_q <= mem[r_ptr];
      end

      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - directed bench for sync_fifo_flags in registered and FWFT modes
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       w_en;
  logic       r_en;
  logic [7:0] data_in;

  logic [7:0] d0, d1;
  logic       full0, empty0, af0, ae0, ov0, un0;
  logic       full1, empty1, af1, ae1, ov1, un1;
  logic [3:0] cnt0, cnt1;

  int tests = 0;
  int fails = 0;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1'b0)) dut_reg (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en), .data_in(data_in),
    .data_out(d0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ov0), .underflow(un0)
  );

  sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en), .data_in(data_in),
    .data_out(d1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ov1), .underflow(un1)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
    cycle(); cycle();
    tests++; if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin fails++; $display("FAIL reset_count got %0d/%0d exp 0", cnt0, cnt1); end
    tests++; if ({full0, empty0, af0, ae0, ov0, un0} !== 6'b010100) begin fails++; $display("FAIL reset_flags_reg got %b exp 010100", {full0, empty0, af0, ae0, ov0, un0}); end
    tests++; if ({full1, empty1, af1, ae1, ov1, un1} !== 6'b010100) begin fails++; $display("FAIL reset_flags_fwft got %b exp 010100", {full1, empty1, af1, ae1, ov1, un1}); end
    tests++; if (d0 !== 8'h00 || d1 !== 8'h00) begin fails++; $display("FAIL reset_dout got %h/%h exp 00/00", d0, d1); end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      w_en = 1'b1; data_in = 8'(i);
      cycle();
      tests++; if (cnt0 !== 4'(i) || cnt1 !== 4'(i)) begin fails++; $display("FAIL fill_count[%0d] got %0d/%0d exp %0d", i, cnt0, cnt1, i); end
      tests++; if ({full0, empty0, af0, ae0} !== {(i == 8), 1'b0, (i >= 6), (i <= 1)}) begin fails++; $display("FAIL fill_flags[%0d] got %b exp %b", i, {full0, empty0, af0, ae0}, {(i == 8), 1'b0, (i >= 6), (i <= 1)}); end
      tests++; if (d1 !== 8'h01 || d0 !== 8'h00) begin fails++; $display("FAIL fill_dout[%0d] got %h/%h exp 00/01", i, d0, d1); end
    end
    data_in = 8'hFF;
    cycle();
    tests++; if (ov0 !== 1'b1 || ov1 !== 1'b1 || cnt0 !== 4'd8) begin fails++; $display("FAIL overflow_pulse got ov=%b/%b cnt=%0d exp 1/1 8", ov0, ov1, cnt0); end
    w_en = 1'b0;
    cycle();
    tests++; if (ov0 !== 1'b0 || ov1 !== 1'b0 || cnt0 !== 4'd8 || full0 !== 1'b1) begin fails++; $display("FAIL overflow_clear got ov=%b/%b cnt=%0d full=%b exp 0/0 8 1", ov0, ov1, cnt0, full0); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      r_en = 1'b1;
      cycle();
      tests++; if (d0 !== 8'(i)) begin fails++; $display("FAIL drain_reg_data[%0d] got %h exp %h", i, d0, 8'(i)); end
      tests++; if (d1 !== ((i < 8) ? 8'(i + 1) : 8'h00)) begin fails++; $display("FAIL drain_fwft_data[%0d] got %h exp %h", i, d1, ((i < 8) ? 8'(i + 1) : 8'h00)); end
      tests++; if (cnt0 !== 4'(8 - i) || {empty0, af0, ae0} !== {(i == 8), (8 - i >= 6), (8 - i <= 1)}) begin fails++; $display("FAIL drain_state[%0d] got cnt=%0d flags=%b exp %0d %b", i, cnt0, {empty0, af0, ae0}, 8 - i, {(i == 8), (8 - i >= 6), (8 - i <= 1)}); end
    end
    cycle();
    tests++; if (un0 !== 1'b1 || un1 !== 1'b1 || d0 !== 8'h08 || d1 !== 8'h00) begin fails++; $display("FAIL underflow_pulse got un=%b/%b d=%h/%h exp 1/1 08/00", un0, un1, d0, d1); end
    r_en = 1'b0;
    cycle();
    tests++; if (un0 !== 1'b0 || un1 !== 1'b0 || cnt0 !== 4'd0 || d0 !== 8'h08) begin fails++; $display("FAIL underflow_clear got un=%b/%b cnt=%0d d=%h exp 0/0 0 08", un0, un1, cnt0, d0); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      w_en = 1'b1; data_in = 8'h10 + 8'(i);
      cycle();
    end
    tests++; if (cnt0 !== 4'd4) begin fails++; $display("FAIL b2b_prefill got %0d exp 4", cnt0); end
    r_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      data_in = 8'h14 + 8'(k);
      cycle();
      tests++; if (cnt0 !== 4'd4 || cnt1 !== 4'd4) begin fails++; $display("FAIL b2b_count[%0d] got %0d/%0d exp 4", k, cnt0, cnt1); end
      tests++; if (d0 !== 8'h10 + 8'(k) || d1 !== 8'h11 + 8'(k)) begin fails++; $display("FAIL b2b_data[%0d] got %h/%h exp %h/%h", k, d0, d1, 8'h10 + 8'(k), 8'h11 + 8'(k)); end
    end
    w_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      tests++; if (d0 !== 8'h24 + 8'(k)) begin fails++; $display("FAIL b2b_tail[%0d] got %h exp %h", k, d0, 8'h24 + 8'(k)); end
    end
    r_en = 1'b0;
    cycle();
    tests++; if (cnt0 !== 4'd0 || empty0 !== 1'b1) begin fails++; $display("FAIL b2b_end got cnt=%0d empty=%b exp 0 1", cnt0, empty0); end
  endtask

  task automatic test_full_empty_simul();
    for (int i = 0; i < 8; i++) begin
      w_en = 1'b1; data_in = 8'h40 + 8'(i);
      cycle();
    end
    r_en = 1'b1; data_in = 8'h99;
    cycle();
    tests++; if (cnt0 !== 4'd7 || ov0 !== 1'b1 || full0 !== 1'b0 || d0 !== 8'h40) begin fails++; $display("FAIL full_simul got cnt=%0d ov=%b full=%b d=%h exp 7 1 0 40", cnt0, ov0, full0, d0); end
    w_en = 1'b0;
    for (int i = 1; i < 8; i++) begin
      cycle();
      tests++; if (d0 !== 8'h40 + 8'(i)) begin fails++; $display("FAIL full_simul_drain[%0d] got %h exp %h", i, d0, 8'h40 + 8'(i)); end
    end
    tests++; if (ov0 !== 1'b0 || empty0 !== 1'b1) begin fails++; $display("FAIL full_simul_end got ov=%b empty=%b exp 0 1", ov0, empty0); end
    w_en = 1'b1; data_in = 8'h5A;
    cycle();
    tests++; if (cnt0 !== 4'd1 || un0 !== 1'b1 || un1 !== 1'b1 || empty0 !== 1'b0) begin fails++; $display("FAIL empty_simul got cnt=%0d un=%b/%b empty=%b exp 1 1/1 0", cnt0, un0, un1, empty0); end
    tests++; if (d0 !== 8'h47 || d1 !== 8'h5A) begin fails++; $display("FAIL empty_simul_data got %h/%h exp 47/5a", d0, d1); end
    w_en = 1'b0;
    cycle();
    tests++; if (d0 !== 8'h5A || cnt0 !== 4'd0 || un0 !== 1'b0) begin fails++; $display("FAIL empty_simul_read got d=%h cnt=%0d un=%b exp 5a 0 0", d0, cnt0, un0); end
    r_en = 1'b0;
  endtask

  task automatic test_fwft_first();
    w_en = 1'b1; data_in = 8'hA5;
    cycle();
    w_en = 1'b0;
    tests++; if (empty1 !== 1'b0 || d1 !== 8'hA5) begin fails++; $display("FAIL fwft_first got empty=%b d=%h exp 0 a5", empty1, d1); end
    cycle();
    tests++; if (d1 !== 8'hA5 || d0 !== 8'h5A) begin fails++; $display("FAIL fwft_hold got %h/%h exp 5a/a5", d0, d1); end
    r_en = 1'b1;
    cycle();
    r_en = 1'b0;
    tests++; if (d0 !== 8'hA5 || d1 !== 8'h00 || empty1 !== 1'b1) begin fails++; $display("FAIL fwft_read got %h/%h empty=%b exp a5/00 1", d0, d1, empty1); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      w_en = 1'b1; data_in = 8'h70 + 8'(i);
      cycle();
    end
    w_en = 1'b0; r_en = 1'b1;
    cycle();
    r_en = 1'b0;
    tests++; if (cnt0 !== 4'd4 || d0 !== 8'h70) begin fails++; $display("FAIL arst_pre got cnt=%0d d=%h exp 4 70", cnt0, d0); end
    w_en = 1'b1; data_in = 8'h75;
    cycle();
    w_en = 1'b0;
    tests++; if (cnt0 !== 4'd5) begin fails++; $display("FAIL arst_count5 got %0d exp 5", cnt0); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (cnt0 !== 4'd0 || cnt1 !== 4'd0 || {full0, empty0, af0, ae0, ov0, un0} !== 6'b010100) begin fails++; $display("FAIL arst_immediate got cnt=%0d/%0d flags=%b exp 0/0 010100", cnt0, cnt1, {full0, empty0, af0, ae0, ov0, un0}); end
    tests++; if (d0 !== 8'h00 || d1 !== 8'h00) begin fails++; $display("FAIL arst_dout got %h/%h exp 00/00", d0, d1); end
    w_en = 1'b1; r_en = 1'b1; data_in = 8'hEE;
    cycle(); cycle();
    tests++; if (cnt0 !== 4'd0 || ov0 !== 1'b0 || un0 !== 1'b0 || ov1 !== 1'b0 || un1 !== 1'b0) begin fails++; $display("FAIL arst_ignore got cnt=%0d ov=%b un=%b exp 0 0 0", cnt0, ov0, un0); end
    w_en = 1'b0; r_en = 1'b0;
    #2;
    rst_n = 1'b1;
    cycle();
    w_en = 1'b1; data_in = 8'h3C;
    cycle();
    w_en = 1'b0;
    tests++; if (cnt0 !== 4'd1 || d1 !== 8'h3C) begin fails++; $display("FAIL arst_write got cnt=%0d d=%h exp 1 3c", cnt0, d1); end
    r_en = 1'b1;
    cycle();
    r_en = 1'b0;
    tests++; if (d0 !== 8'h3C || empty0 !== 1'b1) begin fails++; $display("FAIL arst_read got d=%h empty=%b exp 3c 1", d0, empty0); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_empty_simul();
    test_fwft_first();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter: DEPTH, default 8, storage words; power of two, >=2.
REQ-003 Parameter: AF_LEVEL, default DEPTH-2, almost_full threshold (1..DEPTH-1).
REQ-004 Parameter: AE_LEVEL, default 1, almost_empty threshold (0..DEPTH-2, < AF_LEVEL).
REQ-005 Parameter: FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-007 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-008 Port: w_en  input  1  write request.
REQ-009 Port: r_en  input  1  read request.
REQ-010 Port: data_in  input  WIDTH  write data.
REQ-011 Port: data_out  output  WIDTH  read data.
REQ-012 Port: full, empty  output  1 each  occupancy == DEPTH / == 0.
REQ-013 Port: almost_full, almost_empty  output  1 each  occupancy >= AF_LEVEL / <= AE_LEVEL.
REQ-014 Port: count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 Port: overflow, underflow  output  1 each  one-cycle pulse on rejected write / rejected read.

Function
REQ-016 Write accepted iff w_en=1 and full=0 at the edge; word stored at w_ptr, w_ptr increments modulo DEPTH.
REQ-017 Read accepted iff r_en=1 and empty=0 at the edge; r_ptr increments modulo DEPTH.
REQ-018 Flags use pre-edge state only: write while full is rejected even if a read is accepted on the same edge; read while empty is rejected even if a write is accepted on the same edge.
REQ-019 Simultaneous accepted write and read: count unchanged; both pointers advance; no flag change.
REQ-020 count next = count + accepted_write - accepted_read; never exceeds DEPTH, never below 0.
REQ-021 full, empty, almost_full, almost_empty are registered, computed from next count, valid the cycle after the edge that changes count.
REQ-022 Pointer wrap-around transparent: data order preserved across any number of wraps.
REQ-023 overflow = 1 for exactly one cycle after an edge with w_en=1 and full=1; FIFO contents, pointers, count unchanged.
REQ-024 underflow = 1 for exactly one cycle after an edge with r_en=1 and empty=1; data_out unchanged.
REQ-025 FWFT=0: data_out registered; updated with head word on the edge accepting a read (1-cycle latency); holds value otherwise.
REQ-026 FWFT=1: data_out = head word (mem[r_ptr]) whenever empty=0; 0 whenever empty=1; accepted read presents next word the following cycle.
REQ-027 FWFT=1: first word written to an empty FIFO visible on data_out the cycle after its write edge (empty falls the same cycle).
REQ-028 Storage is a WIDTH x DEPTH register array; contents not reset.

Reset
REQ-029 rst_n=0 asynchronously forces: w_ptr=0, r_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0.
REQ-030 Reset mid-operation discards all stored words; after rst_n rises, first accepted write is the first word read.
REQ-031 w_en/r_en during reset ignored; no pulses generated.

Verification (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1, both FWFT values)
REQ-032 Reset, write 0x01..0x08 -> count 1..8, almost_empty clears at count=2, almost_full sets at count=6, full=1 at count=8; 9th write 0xFF -> overflow one cycle, count stays 8.
REQ-033 Read 8 from full -> data 0x01..0x08 in order (FWFT=0: one cycle after each read edge), empty=1 after 8th; further read -> underflow one cycle, data_out holds 0x08 (FWFT=0) / 0 (FWFT=1).
REQ-034 With count=4, w_en=r_en=1 for 20 cycles, incrementing data -> count stays 4, output sequence contiguous across pointer wraps.
REQ-035 Full FIFO, w_en=r_en=1 -> read accepted, write rejected, overflow pulse, count=7; empty FIFO, w_en=r_en=1 -> write accepted, underflow pulse, count=1.
REQ-036 FWFT=1: write 0xA5 into empty -> next cycle empty=0, data_out=0xA5 without r_en.
REQ-037 Assert rst_n=0 asynchronously (between edges) with count=5 -> all outputs at REQ-029 values immediately; after release write 0x3C, read -> 0x3C.
